f3_wr_pack: RTL

Write-side packer for the F3 feature buffer. Takes a serial stream of signed activations from the F3 compute stage, optionally applies ReLU, and packs eight samples into one 96-bit word. Writes each word to the F3 RAM write port (`f3_wdata`/`f3_wr_en`/`f3_waddr`) at sequential addresses, one frame per `frame_start`.

---
 rtl/f3_wr_pack.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/f3_wr_pack.sv
// Write-side packer for the F3 feature buffer: packs LANES signed samples per RAM word.
// Optional ReLU clamp enabled by defining F3_WR_PACK_RELU_EN.
module f3_wr_pack #(
  parameter int DATA_W = 12,
  parameter int LANES  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    din_valid,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_last,
  output logic                    din_ready,
  output logic [LANES*DATA_W-1:0] f3_wdata,
  output logic                    f3_wr_en,
  output logic [ADDR_W-1:0]       f3_waddr,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORD_W = LANES * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  state_t              state_base;
  logic [LANE_W-1:0]   lane_base;
  logic [ADDR_W-1:0]   addr_base;
  logic [WORD_W-1:0]   word_base;
  logic [WORD_W-1:0]   word_ins;
  logic [DATA_W-1:0]   sample;
  logic                accept;

  assign din_ready = frame_start | (state_q == S_RUN);
  assign accept    = din_valid & din_ready;

  // Sample conditioning ahead of packing
  always_comb begin
`ifdef F3_WR_PACK_RELU_EN
    if (din[DATA_W-1]) begin
      sample = {DATA_W{1'b0}};
    end else begin
      sample = din;
    end
`else
    sample = din;
`endif
  end

  // Next-state logic; frame_start rebases the frame before the sample is applied
  always_comb begin
    state_base = frame_start ? S_RUN : state_q;
    lane_base  = frame_start ? {LANE_W{1'b0}} : lane_q;
    addr_base  = frame_start ? {ADDR_W{1'b0}} : addr_q;
    word_base  = frame_start ? {WORD_W{1'b0}} : word_q;

    state_d  = state_base;
    lane_d   = lane_base;
    addr_d   = addr_base;
    word_d   = word_base;
    ovf_d    = frame_start ? 1'b0 : ovf_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;

    word_ins = word_base;
    for (int k = 0; k < LANES; k++) begin
      if (lane_base == LANE_W'(k)) begin
        word_ins[k*DATA_W +: DATA_W] = sample;
      end else begin
        word_ins[k*DATA_W +: DATA_W] = word_base[k*DATA_W +: DATA_W];
      end
    end

    if (accept) begin
      if ((lane_base == LANE_W'(LANES - 1)) || din_last) begin
        wr_d    = 1'b1;
        wdata_d = word_ins;
        waddr_d = addr_base;
        word_d  = {WORD_W{1'b0}};
        lane_d  = {LANE_W{1'b0}};
        if (din_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (addr_base == {ADDR_W{1'b1}}) begin
          // No wrap: park in FULL until the next frame_start
          ovf_d   = 1'b1;
          state_d = S_FULL;
        end else begin
          addr_d  = addr_base + ADDR_W'(1);
          state_d = S_RUN;
        end
      end else begin
        word_d = word_ins;
        lane_d = lane_base + LANE_W'(1);
      end
    end else begin
      word_d = word_base;
    end
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lane_q  <= {LANE_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      word_q  <= {WORD_W{1'b0}};
      wdata_q <= {WORD_W{1'b0}};
      waddr_q <= {ADDR_W{1'b0}};
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign f3_wdata   = wdata_q;
  assign f3_waddr   = waddr_q;
  assign f3_wr_en   = wr_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule
